bus_gnrtr_arbiter: RTL and testbench

- Shared-bus generator and arbiter connecting `drvrs` devices, each fronted by a show-ahead FIFO.
- A round-robin arbiter picks one device with a pending packet, pops it and routes it to the device(s) named in the packet's 8-bit destination ID.
- Supports unicast and broadcast.
- Sits between the per-device FIFO/driver layer and the monitors that observe each device's receive side.

---
 rtl/bus_gnrtr_arbiter_if.sv | 28 ++
 rtl/bus_gnrtr_arbiter.sv | 101 ++++++++++
 tb/tb_bus_gnrtr_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/bus_gnrtr_arbiter_if.sv
// Bus bundle between the per-device FIFO/driver layer and the arbiter.
// master = arbiter side, slave = device/FIFO side.
interface bus_gnrtr_arbiter_if #(
    parameter int unsigned Drvrs  = 4,
    parameter int unsigned PckgSz = 16
);
    logic [Drvrs-1:0]             pndng;
    logic [Drvrs-1:0][PckgSz-1:0] d_pop;
    logic [Drvrs-1:0]             pop;
    logic [Drvrs-1:0]             push;
    logic [Drvrs-1:0][PckgSz-1:0] d_push;

    modport master (
        input  pndng,
        input  d_pop,
        output pop,
        output push,
        output d_push
    );

    modport slave (
        output pndng,
        output d_pop,
        input  pop,
        input  push,
        input  d_push
    );
endinterface

// File: rtl/bus_gnrtr_arbiter.sv
// Round-robin shared-bus arbiter: pops one pending device FIFO, then delivers
// the packet unicast or broadcast (all but the source) on the following edge.
module bus_gnrtr_arbiter #(
    parameter int unsigned Drvrs     = 4,
    parameter int unsigned PckgSz    = 16,
    parameter logic [7:0]  Broadcast = 8'hFF
) (
    input  logic                clk_i,
    input  logic                reset_i,
    bus_gnrtr_arbiter_if.master bus
);
    localparam int unsigned IdxW = (Drvrs > 1) ? $clog2(Drvrs) : 1;

    typedef enum logic {StIdle, StSend} state_e;

    state_e                       state_q, state_d;
    logic [IdxW-1:0]              rr_q, rr_d;
    logic [IdxW-1:0]              src_q, src_d;
    logic [PckgSz-1:0]            pkt_q, pkt_d;
    logic [Drvrs-1:0]             pop_q, pop_d;
    logic [Drvrs-1:0]             push_q, push_d;
    logic [Drvrs-1:0][PckgSz-1:0] d_push_q, d_push_d;

    logic            gnt_found;
    logic [IdxW-1:0] gnt_idx;
    int unsigned     cand;
    logic [7:0]      pkt_id;

    assign pkt_id = pkt_q[PckgSz-1 -: 8];

    // First pending device at or after the round-robin pointer, with wrap.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int unsigned k = 0; k < Drvrs; k++) begin
            cand = (32'(rr_q) + k) % Drvrs;
            if (!gnt_found && bus.pndng[cand[IdxW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        src_d    = src_q;
        pkt_d    = pkt_q;
        pop_d    = '0;
        push_d   = '0;
        d_push_d = d_push_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    pop_d[gnt_idx] = 1'b1;
                    pkt_d          = bus.d_pop[gnt_idx];
                    src_d          = gnt_idx;
                    state_d        = StSend;
                end
            end
            StSend: begin
                if (pkt_id == Broadcast) begin
                    push_d        = '1;
                    push_d[src_q] = 1'b0;
                end else if (32'(pkt_id) < Drvrs) begin
                    push_d[pkt_id[IdxW-1:0]] = 1'b1;
                end
                // Lanes carry the packet regardless; push bits qualify them.
                d_push_d = {Drvrs{pkt_q}};
                rr_d     = (32'(src_q) == Drvrs - 1) ? '0 : src_q + 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            src_q    <= '0;
            pkt_q    <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            d_push_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            src_q    <= src_d;
            pkt_q    <= pkt_d;
            pop_q    <= pop_d;
            push_q   <= push_d;
            d_push_q <= d_push_d;
        end
    end

    assign bus.pop    = pop_q;
    assign bus.push   = push_q;
    assign bus.d_push = d_push_q;
endmodule

// File: tb/tb_bus_gnrtr_arbiter.sv
// Bench for bus_gnrtr_arbiter: FIFO models per device, transaction-level
// reference of grant/delivery, directed scenarios then random traffic.
module tb_bus_gnrtr_arbiter;
    localparam int N = 4;
    localparam int W = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    bus_gnrtr_arbiter_if #(.Drvrs(N), .PckgSz(W)) bus_if ();

    bus_gnrtr_arbiter #(
        .Drvrs    (N),
        .PckgSz   (W),
        .Broadcast(8'hFF)
    ) dut (
        .clk_i  (clk),
        .reset_i(reset),
        .bus    (bus_if.master)
    );

    int checks = 0;
    int failures = 0;

    logic [W-1:0] fifo [N][$];

    // Reference: an accepted packet is delivered on the next edge.
    int                   m_rr = 0;
    bit                   m_busy = 1'b0;
    logic [W-1:0]         m_pkt = '0;
    int                   m_src = 0;
    logic [N-1:0][W-1:0]  m_dp = '0;

    int gnt_log[$];
    int push0_cnt = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [N-1:0] dest_mask(input logic [W-1:0] pkt, input int src);
        int id;
        logic [N-1:0] m;
        id = int'(pkt[W-1 -: 8]);
        m  = '0;
        if (id == 255) begin
            for (int i = 0; i < N; i++) m[i] = (i != src);
        end else if (id < N) begin
            m[id] = 1'b1;
        end
        return m;
    endfunction

    task automatic drive_inputs();
        logic [N-1:0]        pn;
        logic [N-1:0][W-1:0] dp;
        pn = '0;
        dp = '0;
        for (int i = 0; i < N; i++) begin
            if (fifo[i].size() != 0) begin
                pn[i] = 1'b1;
                dp[i] = fifo[i][0];
            end
        end
        bus_if.pndng = pn;
        bus_if.d_pop = dp;
    endtask

    task automatic step(input string tag);
        logic [N-1:0] e_pop;
        logic [N-1:0] e_push;
        int g;
        e_pop  = '0;
        e_push = '0;
        if (reset) begin
            m_rr   = 0;
            m_busy = 1'b0;
            m_dp   = '0;
        end else if (m_busy) begin
            e_push = dest_mask(m_pkt, m_src);
            for (int i = 0; i < N; i++) m_dp[i] = m_pkt;
            m_rr   = (m_src + 1) % N;
            m_busy = 1'b0;
        end else if (bus_if.pndng != '0) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (g < 0 && bus_if.pndng[(m_rr + k) % N]) g = (m_rr + k) % N;
            end
            e_pop[g] = 1'b1;
            m_pkt    = bus_if.d_pop[g];
            m_src    = g;
            m_busy   = 1'b1;
        end
        @(posedge clk);
        #1;
        check_eq({tag, "_pop"}, 64'(bus_if.pop), 64'(e_pop));
        check_eq({tag, "_push"}, 64'(bus_if.push), 64'(e_push));
        check_eq({tag, "_dpush"}, 64'(bus_if.d_push), 64'(m_dp));
        for (int i = 0; i < N; i++) if (bus_if.pop[i]) gnt_log.push_back(i);
        if (bus_if.push[0]) push0_cnt++;
        if (e_pop != '0) void'(fifo[m_src].pop_front());
        drive_inputs();
    endtask

    task automatic drain();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 64; i++) begin
            done = !m_busy;
            for (int d = 0; d < N; d++) if (fifo[d].size() != 0) done = 1'b0;
            if (done) break;
            step("drain");
        end
        check_eq("drain_bound", 64'(done), 64'd1);
    endtask

    task automatic fill_all(input logic [W-1:0] pkt);
        for (int i = 0; i < N; i++) fifo[i].push_back(pkt);
        drive_inputs();
    endtask

    initial begin
        logic [7:0] id;
        drive_inputs();

        // Reset with every device pending.
        fill_all(16'h0000);
        reset = 1'b1;
        repeat (5) step("rst");
        check_eq("rst_push_zero", 64'(bus_if.push), 64'd0);
        reset = 1'b0;
        step("rst_rel");
        check_eq("rst_first_gnt", 64'(bus_if.pop), 64'b0001);
        drain();

        // Unicast 2 -> 1.
        fifo[2].push_back(16'h01AB);
        drive_inputs();
        step("uni");
        check_eq("uni_pop", 64'(bus_if.pop), 64'b0100);
        step("uni");
        check_eq("uni_push", 64'(bus_if.push), 64'b0010);
        check_eq("uni_lane1", 64'(bus_if.d_push[1]), 64'h01AB);
        step("uni_idle");
        check_eq("uni_idle_push", 64'(bus_if.push), 64'd0);

        // Broadcast from 1.
        fifo[1].push_back(16'hFF55);
        drive_inputs();
        step("bc");
        check_eq("bc_pop", 64'(bus_if.pop), 64'b0010);
        step("bc");
        check_eq("bc_push", 64'(bus_if.push), 64'b1101);
        check_eq("bc_lanes", 64'(bus_if.d_push), 64'hFF55_FF55_FF55_FF55);
        step("bc_idle");

        // Invalid destination from 3: dropped, pointer wraps to 0.
        fifo[3].push_back(16'h0711);
        drive_inputs();
        step("inv");
        check_eq("inv_pop", 64'(bus_if.pop), 64'b1000);
        step("inv");
        check_eq("inv_push", 64'(bus_if.push), 64'd0);
        fill_all(16'h0000);
        step("inv_rr");
        check_eq("inv_rr_gnt", 64'(bus_if.pop), 64'b0001);
        drain();

        // Round robin: two packets per device, all to device 0.
        reset = 1'b1;
        step("rr_rst");
        reset = 1'b0;
        fill_all(16'h0001);
        fill_all(16'h0002);
        gnt_log.delete();
        push0_cnt = 0;
        repeat (16) step("rr");
        check_eq("rr_gnt_count", 64'(gnt_log.size()), 64'd8);
        for (int i = 0; i < gnt_log.size() && i < 8; i++)
            check_eq($sformatf("rr_gnt%0d", i), 64'(gnt_log[i]), 64'(i % N));
        check_eq("rr_push0_count", 64'(push0_cnt), 64'd8);
        drain();

        // Reset at the edge where delivery would happen.
        step("pre_mid");
        fifo[1].push_back(16'h0233);
        drive_inputs();
        step("mid");
        check_eq("mid_pop", 64'(bus_if.pop), 64'b0010);
        reset = 1'b1;
        step("mid_rst");
        check_eq("mid_no_push", 64'(bus_if.push), 64'd0);
        reset = 1'b0;
        step("mid_idle");
        check_eq("mid_idle_push", 64'(bus_if.push), 64'd0);
        fill_all(16'h0100);
        step("mid_rr");
        check_eq("mid_rr_gnt", 64'(bus_if.pop), 64'b0001);
        drain();

        // Random traffic and occasional resets.
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                int d;
                d = $urandom_range(0, N - 1);
                case ($urandom_range(0, 3))
                    0:       id = 8'hFF;
                    1:       id = 8'($urandom_range(4, 254));
                    default: id = 8'($urandom_range(0, N - 1));
                endcase
                if (fifo[d].size() < 3) fifo[d].push_back({id, 8'($urandom)});
                drive_inputs();
            end
            reset = ($urandom_range(0, 63) == 0);
            step("rnd");
        end
        reset = 1'b0;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
